// File: rtl/text_video_engine.sv
// Text-mode raster engine: VGA timing, char buffer/ROM fetch pipeline,
// scroll wrap, cursor modes and whole-screen invert.
module text_video_engine #(
    parameter int COLS      = 80,
    parameter int ROWS      = 24,
    parameter int COL_BITS  = 7,
    parameter int ROW_BITS  = 5,
    parameter int ADDR_BITS = 11,
    parameter int CHAR_W    = 8,
    parameter int CHAR_H    = 16,
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int V_OFFSET  = 48,
    parameter int SYNC_NEG  = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    output logic                      hsync,
    output logic                      vsync,
    output logic                      video,
    output logic                      hblank,
    output logic                      vblank,
    input  logic [COL_BITS-1:0]       cursor_x,
    input  logic [ROW_BITS-1:0]       cursor_y,
    input  logic                      cursor_blink_on,
    input  logic [1:0]                cursor_mode,
    input  logic                      invert,
    input  logic [ADDR_BITS-1:0]      first_char,
    output logic [ADDR_BITS-1:0]      char_address,
    input  logic [7:0]                char,
    output logic [$clog2(CHAR_H)+7:0] char_rom_address,
    input  logic [CHAR_W-1:0]         char_rom_data
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int LB      = $clog2(CHAR_H);
    localparam int PW      = (CHAR_W > 1) ? $clog2(CHAR_W) : 1;
    localparam int AW1     = ADDR_BITS + 1;

    localparam logic [HW-1:0] H_END  = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [HW-1:0] H_TXT  = HW'(COLS * CHAR_W);

    localparam logic [VW-1:0] V_END  = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [VW-1:0] V_TOP  = VW'(V_OFFSET);
    localparam logic [VW-1:0] V_BOT  = VW'(V_OFFSET + ROWS * CHAR_H);

    localparam logic [PW-1:0]       P_END   = PW'(CHAR_W - 1);
    localparam logic [COL_BITS-1:0] COL_END = COL_BITS'(COLS - 1);
    localparam logic [ROW_BITS-1:0] ROW_END = ROW_BITS'(ROWS - 1);
    localparam logic [LB-1:0]       L_LAST  = LB'(CHAR_H - 1);
    localparam logic [LB-1:0]       L_UNDER = LB'(CHAR_H - 2);
    localparam logic [AW1-1:0]      N_CELLS = AW1'(COLS * ROWS);
    localparam logic [AW1-1:0]      COLS_A  = AW1'(COLS);

    // Idle level of both sync outputs.
    localparam logic IDLE = (SYNC_NEG != 0);

    typedef struct packed {
        logic hs;
        logic vs;
        logic hb;
        logic vb;
        logic text;
        logic cur;
        logic inv;
    } ctl_t;

    localparam ctl_t CTL_RST = '{
        hs: IDLE, vs: IDLE, hb: 1'b1, vb: 1'b1,
        text: 1'b0, cur: 1'b0, inv: 1'b0
    };

    logic [HW-1:0]        h_cnt;
    logic [VW-1:0]        v_cnt;
    logic [PW-1:0]        px_cnt;
    logic [COL_BITS-1:0]  col_cnt;
    logic [ROW_BITS-1:0]  row_cnt;
    logic [ADDR_BITS-1:0] row_base;
    logic                 inv_frame;

    logic                 h_wrap;
    logic                 v_wrap;
    logic                 frame_start;
    logic                 h_text;
    logic                 v_text;
    logic                 in_text;
    logic                 row_end;
    logic                 under;
    logic                 hit;
    logic [LB-1:0]        line0;
    logic [AW1-1:0]       first_ext;
    logic [AW1-1:0]       addr_sum;
    logic [AW1-1:0]       row_sum;
    logic [ADDR_BITS-1:0] first_w;
    logic [ADDR_BITS-1:0] base;
    logic [ADDR_BITS-1:0] row_next;
    ctl_t                 c0;
    logic [PW-1:0]        bit0;

    ctl_t                 c1;
    logic [PW-1:0]        px1;
    logic [LB-1:0]        line1;

    ctl_t                 c2;
    logic [PW-1:0]        px2;
    logic                 vid2;

    // S0 decode: raster position, buffer address and per-pixel control.
    always_comb begin
        h_wrap      = (h_cnt == H_END);
        v_wrap      = (v_cnt == V_END);
        frame_start = (h_cnt == '0) && (v_cnt == '0);
        h_text      = (h_cnt < H_TXT);
        v_text      = (v_cnt >= V_TOP) && (v_cnt < V_BOT);
        in_text     = h_text && v_text;

        first_ext = {1'b0, first_char};
        first_w   = ADDR_BITS'((first_ext >= N_CELLS) ?
                               first_ext - N_CELLS : first_ext);
        base      = frame_start ? first_w : row_base;

        addr_sum     = {1'b0, base} + AW1'(col_cnt);
        char_address = ADDR_BITS'((addr_sum >= N_CELLS) ?
                                  addr_sum - N_CELLS : addr_sum);

        row_sum  = {1'b0, row_base} + COLS_A;
        row_next = ADDR_BITS'((row_sum >= N_CELLS) ?
                              row_sum - N_CELLS : row_sum);

        line0   = LB'(v_cnt - V_TOP);
        row_end = h_wrap && v_text && (line0 == L_LAST);
        under   = (line0 >= L_UNDER);
        hit     = in_text && (cursor_x == col_cnt) &&
                  (cursor_y == row_cnt);

        c0      = CTL_RST;
        c0.hs   = ((h_cnt >= HS_BEG) && (h_cnt < HS_END)) ^ IDLE;
        c0.vs   = ((v_cnt >= VS_BEG) && (v_cnt < VS_END)) ^ IDLE;
        c0.hb   = (h_cnt >= H_ACT);
        c0.vb   = (v_cnt >= V_ACT);
        c0.text = in_text;
        c0.inv  = frame_start ? invert : inv_frame;
        case (cursor_mode)
            2'd1:    c0.cur = hit && cursor_blink_on;
            2'd2:    c0.cur = hit && cursor_blink_on && under;
            2'd3:    c0.cur = hit;
            default: c0.cur = 1'b0;
        endcase

        bit0 = P_END - px_cnt;
    end

    // Raster counters, text cell tracking and per-frame sampled settings.
    always_ff @(posedge clk) begin
        if (reset) begin
            h_cnt     <= '0;
            v_cnt     <= '0;
            px_cnt    <= '0;
            col_cnt   <= '0;
            row_cnt   <= '0;
            row_base  <= first_w;
            inv_frame <= 1'b0;
        end else begin
            h_cnt <= h_wrap ? '0 : h_cnt + 1'b1;
            if (h_wrap)
                v_cnt <= v_wrap ? '0 : v_cnt + 1'b1;

            if (h_wrap || px_cnt == P_END)
                px_cnt <= '0;
            else
                px_cnt <= px_cnt + 1'b1;

            // Column saturates at the last cell so the address never
            // runs past the row once the beam is in the right border.
            if (h_wrap)
                col_cnt <= '0;
            else if (px_cnt == P_END && col_cnt != COL_END)
                col_cnt <= col_cnt + 1'b1;

            if (frame_start) begin
                row_base  <= first_w;
                row_cnt   <= '0;
                inv_frame <= invert;
            end else if (row_end) begin
                row_base <= row_next;
                if (row_cnt != ROW_END)
                    row_cnt <= row_cnt + 1'b1;
            end
        end
    end

    // S1: char byte arrives from the buffer and forms the ROM address.
    assign char_rom_address = {char, line1};

    // S0 -> S1 pipeline register.
    always_ff @(posedge clk) begin
        if (reset) begin
            c1    <= CTL_RST;
            px1   <= '0;
            line1 <= '0;
        end else begin
            c1    <= c0;
            px1   <= bit0;
            line1 <= line0;
        end
    end

    // S1 -> S2 pipeline register.
    always_ff @(posedge clk) begin
        if (reset) begin
            c2  <= CTL_RST;
            px2 <= '0;
        end else begin
            c2  <= c1;
            px2 <= px1;
        end
    end

    // S2: select the glyph bit and apply cursor and screen inversion.
    always_comb begin
        vid2 = c2.inv;
        if (c2.text)
            vid2 = char_rom_data[px2] ^ c2.cur ^ c2.inv;
    end

    // S3: registered pins, all aligned three clocks behind the counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            hsync  <= IDLE;
            vsync  <= IDLE;
            hblank <= 1'b1;
            vblank <= 1'b1;
            video  <= 1'b0;
        end else begin
            hsync  <= c2.hs;
            vsync  <= c2.vs;
            hblank <= c2.hb;
            vblank <= c2.vb;
            video  <= vid2;
        end
    end

endmodule

// File: tb/tb_text_video_engine.sv
// Randomised bench for text_video_engine on a small raster,
// checked per clock against a position-based reference model.
module tb_text_video_engine;

    localparam int COLS  = 10;
    localparam int ROWS  = 4;
    localparam int CW    = 8;
    localparam int CH    = 4;
    localparam int HA    = 96;
    localparam int HF    = 4;
    localparam int HS    = 8;
    localparam int HB    = 4;
    localparam int VA    = 24;
    localparam int VF    = 2;
    localparam int VS    = 2;
    localparam int VB    = 2;
    localparam int VO    = 4;
    localparam int HT    = HA + HF + HS + HB;
    localparam int VT    = VA + VF + VS + VB;
    localparam int FRAME = HT * VT;
    localparam int CELLS = COLS * ROWS;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       hsync, vsync, video, hblank, vblank;
    logic [3:0] cursor_x = '0;
    logic [2:0] cursor_y = '0;
    logic       cursor_blink_on = 1'b0;
    logic [1:0] cursor_mode = '0;
    logic       invert = 1'b0;
    logic [5:0] first_char = '0;
    logic [5:0] char_address;
    logic [7:0] char;
    logic [9:0] char_rom_address;
    logic [7:0] char_rom_data;

    logic [7:0] mem [0:63];
    logic [7:0] rom [0:1023];
    logic       rom_force = 1'b0;
    logic [7:0] rom_val = '0;

    int         n_checks = 0;
    int         n_errors = 0;
    int         t = 0;
    int         fc_frame = 0;
    logic       inv_frame = 1'b0;
    logic [4:0] hist [3];
    logic       rom_vld = 1'b0;
    logic [9:0] rom_exp = '0;
    int         lit = 0;
    int         hs_first = -1;
    int         vs_first = -1;

    localparam logic [4:0] RST_OUT = 5'b11110;

    text_video_engine #(
        .COLS(COLS), .ROWS(ROWS), .COL_BITS(4), .ROW_BITS(3),
        .ADDR_BITS(6), .CHAR_W(CW), .CHAR_H(CH),
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .V_OFFSET(VO), .SYNC_NEG(1)
    ) dut (
        .clk(clk),
        .reset(reset),
        .hsync(hsync),
        .vsync(vsync),
        .video(video),
        .hblank(hblank),
        .vblank(vblank),
        .cursor_x(cursor_x),
        .cursor_y(cursor_y),
        .cursor_blink_on(cursor_blink_on),
        .cursor_mode(cursor_mode),
        .invert(invert),
        .first_char(first_char),
        .char_address(char_address),
        .char(char),
        .char_rom_address(char_rom_address),
        .char_rom_data(char_rom_data)
    );

    always #5 clk = ~clk;

    // Synchronous char buffer and glyph ROM, one clock of latency each.
    always @(posedge clk) begin
        char          <= mem[char_address];
        char_rom_data <= rom_force ? rom_val : rom[char_rom_address];
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h exp %0h t=%0d", tag, got, exp, t);
        end
    endtask

    // Compare pins against the model, then predict this position.
    task automatic step();
        int         pos, x, y, col, row, ln, a;
        logic [7:0] g;
        logic       txt, pix, cur, vid;
        logic [4:0] e;
        chk("out", 32'({hsync, vsync, hblank, vblank, video}),
            32'(hist[2]));
        chk("addr_rng", 32'(int'(char_address) < CELLS), 32'd1);
        if (rom_vld)
            chk("rom_addr", 32'(char_rom_address), 32'(rom_exp));

        pos = t % FRAME;
        x   = pos % HT;
        y   = pos / HT;
        if (pos == 0) begin
            fc_frame  = int'(first_char) % CELLS;
            inv_frame = invert;
        end
        txt = (x < COLS * CW) && (y >= VO) && (y < VO + ROWS * CH);
        vid = inv_frame;
        if (txt) begin
            col = x / CW;
            row = (y - VO) / CH;
            ln  = (y - VO) % CH;
            a   = (fc_frame + row * COLS + col) % CELLS;
            g   = rom_force ? rom_val : rom[int'(mem[a]) * CH + ln];
            pix = g[CW - 1 - x % CW];
            cur = (col == int'(cursor_x)) && (row == int'(cursor_y)) &&
                  ((cursor_mode == 2'd3) ||
                   (cursor_mode == 2'd1 && cursor_blink_on) ||
                   (cursor_mode == 2'd2 && cursor_blink_on &&
                    ln >= CH - 2));
            vid = pix ^ cur ^ inv_frame;
            chk("addr", 32'(char_address), 32'(a));
            rom_exp = 10'(int'(mem[a]) * CH + ln);
        end
        rom_vld = txt;
        e = {!(x >= HA + HF && x < HA + HF + HS),
             !(y >= VA + VF && y < VA + VF + VS),
             x >= HA, y >= VA, vid};
        hist[2] = hist[1];
        hist[1] = hist[0];
        hist[0] = e;

        if (video)
            lit++;
        if (hs_first < 0 && !hsync)
            hs_first = t;
        if (vs_first < 0 && !vsync)
            vs_first = t;
        t++;
        @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) @(negedge clk);
        chk("rst_out", 32'({hsync, vsync, hblank, vblank, video}),
            32'(RST_OUT));
        chk("rst_addr", 32'(char_address), 32'(first_char));
        reset    = 1'b0;
        t        = 0;
        hist[0]  = RST_OUT;
        hist[1]  = RST_OUT;
        hist[2]  = RST_OUT;
        rom_vld  = 1'b0;
        lit      = 0;
        hs_first = -1;
        vs_first = -1;
    endtask

    initial begin
        for (int i = 0; i < 64; i++)
            mem[i] = 8'($urandom_range(0, 255));
        for (int i = 0; i < 1024; i++)
            rom[i] = 8'($urandom);

        // Random cursor activity over one frame; sync timing.
        do_reset(5);
        for (int i = 0; i < FRAME + 3; i++) begin
            if (i % 41 == 0) begin
                cursor_x    = 4'($urandom_range(0, COLS - 1));
                cursor_y    = 3'($urandom_range(0, ROWS - 1));
                cursor_mode = 2'($urandom_range(0, 3));
            end
            if (i % 37 == 0)
                cursor_blink_on = 1'($urandom);
            step();
        end
        chk("hs_first", 32'(hs_first), 32'(HA + HF + 3));
        chk("vs_first", 32'(vs_first), 32'((VA + VF) * HT + 3));

        // Scroll wrap, mid-frame first_char change.
        first_char  = 6'd35;
        cursor_mode = 2'd3;
        cursor_x    = 4'd9;
        cursor_y    = 3'd3;
        do_reset(2);
        for (int i = 0; i < 2 * FRAME; i++) begin
            if (i == FRAME / 2)
                first_char = 6'd7;
            step();
        end

        // Underline cursor on blank glyphs.
        rom_force       = 1'b1;
        rom_val         = 8'h00;
        first_char      = 6'd0;
        cursor_x        = 4'd5;
        cursor_y        = 3'd3;
        cursor_mode     = 2'd2;
        cursor_blink_on = 1'b1;
        do_reset(3);
        for (int i = 0; i < FRAME + 3; i++)
            step();
        chk("lit", 32'(lit), 32'(2 * CW));

        // Inverted 0xAA, cursor off by blink, invert dropped mid-frame.
        rom_val         = 8'hAA;
        invert          = 1'b1;
        cursor_mode     = 2'd1;
        cursor_blink_on = 1'b0;
        do_reset(2);
        for (int i = 0; i < 2 * FRAME; i++) begin
            if (i == FRAME / 3)
                invert = 1'b0;
            step();
        end

        // Out-of-range cursor, random modes, mid-frame reset.
        rom_force  = 1'b0;
        cursor_x   = 4'd12;
        cursor_y   = 3'd5;
        first_char = 6'($urandom_range(0, CELLS - 1));
        do_reset(2);
        for (int i = 0; i < 2 * FRAME; i++) begin
            if (i % 29 == 0) begin
                cursor_mode     = 2'($urandom_range(0, 3));
                cursor_blink_on = 1'($urandom);
            end
            if (i == 1234)
                do_reset(1);
            else
                step();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
